// File: rtl/aq_ifu_ras_pkg.sv
// ---------------------------------------------------------------------------
// aq_ifu_ras_pkg
// Shared constants for the IFU return-address stack.
//   RAS_DEPTH_DEF   : default number of stack entries (power of two, 2..32)
//   RAS_PC_W_DEF    : default width of a stored return PC
//   RAS_PTR_W_DEF   : pointer width for the default depth
//   ras_ptr_w()     : pointer width for an arbitrary depth
// ---------------------------------------------------------------------------
package aq_ifu_ras_pkg;

    localparam int RAS_DEPTH_DEF = 8;
    localparam int RAS_PC_W_DEF  = 24;

    // A depth of 2 still needs a one-bit pointer, so clamp at 1.
    function automatic int ras_ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    localparam int RAS_PTR_W_DEF = ras_ptr_w(RAS_DEPTH_DEF);

endpackage

// File: rtl/aq_ifu_ras_stack_entry.sv
// ---------------------------------------------------------------------------
// aq_ifu_ras_stack_entry
// One return-address stack slot: a PC_W register behind its own clock gate,
// clocked only when the slot is being written.
//   forever_cpuclk     : free-running clock
//   cpurst_b           : asynchronous active-low reset (entry clears to 0)
//   cp0_ifu_icg_en     : module clock-gate enable
//   cp0_yy_clk_en      : global clock enable
//   pad_yy_icg_scan_en : scan enable
//   upd                : write this slot on the next edge
//   upd_pc             : PC to write
//   pc                 : stored PC
// ---------------------------------------------------------------------------
module aq_ifu_ras_stack_entry
    import aq_ifu_ras_pkg::*;
#(
    parameter int PC_W = RAS_PC_W_DEF
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst_b,
    input  logic            cp0_ifu_icg_en,
    input  logic            cp0_yy_clk_en,
    input  logic            pad_yy_icg_scan_en,
    input  logic            upd,
    input  logic [PC_W-1:0] upd_pc,
    output logic [PC_W-1:0] pc
);

    logic            entry_clk;
    logic [PC_W-1:0] pc_reg;

    gated_clk_cell u_entry_icg (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_ifu_icg_en),
        .local_en           (upd),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (entry_clk)
    );

    // The clock may still run when the gate is forced on, so qualify with upd.
    always_ff @(posedge entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            pc_reg <= '0;
        end else if (upd) begin
            pc_reg <= upd_pc;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/gated_clk_cell.sv
// ---------------------------------------------------------------------------
// gated_clk_cell
// Latch-based clock gate. The enable is captured while clk_in is low so the
// gated clock never glitches during the high phase.
//   clk_in             : free-running clock
//   global_en          : global clock enable
//   module_en          : module-level enable (forces the clock on when set)
//   local_en           : per-use enable
//   external_en        : extra force-on enable
//   pad_yy_icg_scan_en : scan-mode force-on
//   clk_out            : gated clock
// ---------------------------------------------------------------------------
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en_bf_latch;
    logic clk_en_lat;

    assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

    always_latch begin
        if (!clk_in) begin
            clk_en_lat = clk_en_bf_latch | pad_yy_icg_scan_en;
        end
    end

    assign clk_out = clk_in & clk_en_lat;

endmodule

// File: rtl/aq_ifu_ras_stack.sv
// ---------------------------------------------------------------------------
// aq_ifu_ras_stack
// IFU return-address stack with a speculative pointer (sptr, moved by the
// predictor) and a resolved pointer (bptr, moved by execute). Recovery events
// snap sptr back to bptr. Entries are never cleared by pops; overflow wraps
// and silently overwrites the oldest entry.
//
// Optional feature: define AQ_IFU_RAS_OCC_CHK_EN to add speculative/resolved
// occupancy counters (scnt/bcnt). With it, pops on an empty stack are ignored
// and ras_pred_vld reports a non-empty stack; without it, ras_pred_vld is 1.
//
// Ports
//   forever_cpuclk                 : clock, rising edge
//   cpurst_b                       : asynchronous active-low reset
//   cp0_ifu_icg_en, cp0_yy_clk_en,
//   pad_yy_icg_scan_en             : clock-gating module/global/scan enables
//   pred_ras_link_vld/_link_pc     : speculative push of a return PC
//   pred_ras_ret_vld               : speculative pop
//   ras_cur_st                     : suppresses a speculative pop
//   iu_ifu_link_vld/_ret_vld       : resolved call/return
//   iu_ifu_bht_mispred,
//   iu_ifu_pc_mispred,
//   rtu_ifu_flush_fe               : recovery events
//   *_gate                         : early clock-enable copies
//   ras_pred_tar_pc                : top-of-stack prediction
//   ras_pred_vld                   : prediction usable
// ---------------------------------------------------------------------------
module aq_ifu_ras_stack
    import aq_ifu_ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int PC_W  = RAS_PC_W_DEF
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst_b,
    input  logic            cp0_ifu_icg_en,
    input  logic            cp0_yy_clk_en,
    input  logic            pad_yy_icg_scan_en,
    input  logic            pred_ras_link_vld,
    input  logic [PC_W-1:0] pred_ras_link_pc,
    input  logic            pred_ras_ret_vld,
    input  logic            ras_cur_st,
    input  logic            iu_ifu_link_vld,
    input  logic            iu_ifu_ret_vld,
    input  logic            iu_ifu_bht_mispred,
    input  logic            iu_ifu_pc_mispred,
    input  logic            rtu_ifu_flush_fe,
    input  logic            iu_ifu_link_vld_gate,
    input  logic            iu_ifu_ret_vld_gate,
    input  logic            iu_ifu_bht_mispred_gate,
    input  logic            iu_ifu_pc_mispred_gate,
    output logic [PC_W-1:0] ras_pred_tar_pc,
    output logic            ras_pred_vld
);

    localparam int PTR_W = ras_ptr_w(DEPTH);

    logic             stack_clk;
    logic             stack_clk_en;

    logic             restore;
    logic             push;
    logic             pop_req;
    logic             pop;

    logic [PTR_W-1:0] sptr_reg;
    logic [PTR_W-1:0] sptr_next;
    logic [PTR_W-1:0] bptr_reg;
    logic [PTR_W-1:0] bptr_next;

    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [PC_W-1:0]  entry_pc [DEPTH];

    // ---------------------------------------------------------------------
    // Stack clock gate: any event that can move a pointer wakes the clock.
    // ---------------------------------------------------------------------
    assign stack_clk_en = pred_ras_link_vld | pred_ras_ret_vld
                        | iu_ifu_link_vld | iu_ifu_ret_vld
                        | iu_ifu_bht_mispred | iu_ifu_pc_mispred
                        | rtu_ifu_flush_fe
                        | iu_ifu_link_vld_gate | iu_ifu_ret_vld_gate
                        | iu_ifu_bht_mispred_gate | iu_ifu_pc_mispred_gate;

    gated_clk_cell u_stack_icg (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_ifu_icg_en),
        .local_en           (stack_clk_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (stack_clk)
    );

    // ---------------------------------------------------------------------
    // Event decode. A pc_mispred that is itself a call is handled by the
    // resolved link path rather than by a restore.
    // ---------------------------------------------------------------------
    assign restore = rtu_ifu_flush_fe | iu_ifu_bht_mispred
                   | (iu_ifu_pc_mispred & ~iu_ifu_link_vld);
    assign push    = pred_ras_link_vld;
    assign pop_req = pred_ras_ret_vld & ~ras_cur_st;

`ifdef AQ_IFU_RAS_OCC_CHK_EN
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [CNT_W-1:0] scnt_reg;
    logic [CNT_W-1:0] scnt_next;
    logic [CNT_W-1:0] bcnt_reg;
    logic [CNT_W-1:0] bcnt_next;

    // Popping an empty stack must not move the pointer.
    assign pop = pop_req & (scnt_reg != '0);

    always_comb begin
        scnt_next = scnt_reg;
        if (restore) begin
            scnt_next = bcnt_reg;
        end else if (push && !pop) begin
            if (scnt_reg != CNT_MAX) scnt_next = scnt_reg + CNT_W'(1);
        end else if (pop && !push) begin
            scnt_next = scnt_reg - CNT_W'(1);
        end
    end

    always_comb begin
        bcnt_next = bcnt_reg;
        if (!rtu_ifu_flush_fe) begin
            if (iu_ifu_link_vld && !iu_ifu_ret_vld) begin
                if (bcnt_reg != CNT_MAX) bcnt_next = bcnt_reg + CNT_W'(1);
            end else if (iu_ifu_ret_vld && !iu_ifu_link_vld) begin
                if (bcnt_reg != '0) bcnt_next = bcnt_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge stack_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            scnt_reg <= '0;
            bcnt_reg <= '0;
        end else begin
            scnt_reg <= scnt_next;
            bcnt_reg <= bcnt_next;
        end
    end

    assign ras_pred_vld = (scnt_reg != '0);
`else
    assign pop          = pop_req;
    assign ras_pred_vld = 1'b1;
`endif

    // ---------------------------------------------------------------------
    // Speculative pointer and entry write. Restore wins over the same-cycle
    // push/pop, including its entry write. Push+pop replaces the top.
    // ---------------------------------------------------------------------
    always_comb begin
        sptr_next = sptr_reg;
        wr_en     = 1'b0;
        wr_idx    = sptr_reg + PTR_W'(1);
        if (restore) begin
            sptr_next = bptr_reg;
        end else if (push && pop) begin
            wr_en  = 1'b1;
            wr_idx = sptr_reg;
        end else if (push) begin
            wr_en     = 1'b1;
            sptr_next = sptr_reg + PTR_W'(1);
        end else if (pop) begin
            sptr_next = sptr_reg - PTR_W'(1);
        end
    end

    // Resolved pointer: a front-end flush freezes it; sptr samples the old
    // value on a restore because both registers update on the same edge.
    always_comb begin
        bptr_next = bptr_reg;
        if (!rtu_ifu_flush_fe) begin
            if (iu_ifu_link_vld && !iu_ifu_ret_vld) begin
                bptr_next = bptr_reg + PTR_W'(1);
            end else if (iu_ifu_ret_vld && !iu_ifu_link_vld) begin
                bptr_next = bptr_reg - PTR_W'(1);
            end
        end
    end

    always_ff @(posedge stack_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sptr_reg <= '0;
            bptr_reg <= '0;
        end else begin
            sptr_reg <= sptr_next;
            bptr_reg <= bptr_next;
        end
    end

    // ---------------------------------------------------------------------
    // Entry array
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic entry_upd;
            assign entry_upd = wr_en & (wr_idx == PTR_W'(gi));

            aq_ifu_ras_stack_entry #(
                .PC_W (PC_W)
            ) u_entry (
                .forever_cpuclk     (forever_cpuclk),
                .cpurst_b           (cpurst_b),
                .cp0_ifu_icg_en     (cp0_ifu_icg_en),
                .cp0_yy_clk_en      (cp0_yy_clk_en),
                .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
                .upd                (entry_upd),
                .upd_pc             (pred_ras_link_pc),
                .pc                 (entry_pc[gi])
            );
        end
    endgenerate

    assign ras_pred_tar_pc = entry_pc[sptr_reg];

endmodule

// File: tb/tb_aq_ifu_ras_stack.sv
// ---------------------------------------------------------------------------
// tb_aq_ifu_ras_stack
// Directed scenarios followed by random traffic, compared every cycle with a
// behavioural stack model (array + modular pointers). Honours
// AQ_IFU_RAS_OCC_CHK_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_aq_ifu_ras_stack;

    localparam int DEPTH = 8;
    localparam int PC_W  = 24;

    logic            clk;
    logic            cpurst_b;
    logic            cp0_ifu_icg_en;
    logic            cp0_yy_clk_en;
    logic            pad_yy_icg_scan_en;
    logic            pred_ras_link_vld;
    logic [PC_W-1:0] pred_ras_link_pc;
    logic            pred_ras_ret_vld;
    logic            ras_cur_st;
    logic            iu_ifu_link_vld;
    logic            iu_ifu_ret_vld;
    logic            iu_ifu_bht_mispred;
    logic            iu_ifu_pc_mispred;
    logic            rtu_ifu_flush_fe;
    logic [PC_W-1:0] ras_pred_tar_pc;
    logic            ras_pred_vld;

    int n_checks;
    int n_pass;

    // Reference model
    logic [PC_W-1:0] m_stk [DEPTH];
    int              m_sp;
    int              m_bp;
`ifdef AQ_IFU_RAS_OCC_CHK_EN
    int              m_sc;
    int              m_bc;
`endif

    aq_ifu_ras_stack #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) dut (
        .forever_cpuclk          (clk),
        .cpurst_b                (cpurst_b),
        .cp0_ifu_icg_en          (cp0_ifu_icg_en),
        .cp0_yy_clk_en           (cp0_yy_clk_en),
        .pad_yy_icg_scan_en      (pad_yy_icg_scan_en),
        .pred_ras_link_vld       (pred_ras_link_vld),
        .pred_ras_link_pc        (pred_ras_link_pc),
        .pred_ras_ret_vld        (pred_ras_ret_vld),
        .ras_cur_st              (ras_cur_st),
        .iu_ifu_link_vld         (iu_ifu_link_vld),
        .iu_ifu_ret_vld          (iu_ifu_ret_vld),
        .iu_ifu_bht_mispred      (iu_ifu_bht_mispred),
        .iu_ifu_pc_mispred       (iu_ifu_pc_mispred),
        .rtu_ifu_flush_fe        (rtu_ifu_flush_fe),
        .iu_ifu_link_vld_gate    (iu_ifu_link_vld),
        .iu_ifu_ret_vld_gate     (iu_ifu_ret_vld),
        .iu_ifu_bht_mispred_gate (iu_ifu_bht_mispred),
        .iu_ifu_pc_mispred_gate  (iu_ifu_pc_mispred),
        .ras_pred_tar_pc         (ras_pred_tar_pc),
        .ras_pred_vld            (ras_pred_vld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_pc(input string tag, input logic [PC_W-1:0] obs,
                          input logic [PC_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: tar_pc got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    function automatic logic model_vld();
`ifdef AQ_IFU_RAS_OCC_CHK_EN
        return (m_sc != 0);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_stk[i] = '0;
        m_sp = 0;
        m_bp = 0;
`ifdef AQ_IFU_RAS_OCC_CHK_EN
        m_sc = 0;
        m_bc = 0;
`endif
    endtask

    // Applies one cycle of the stack rules to the model.
    task automatic model_step(input logic plink, input logic [PC_W-1:0] lpc,
                              input logic pret, input logic cst,
                              input logic ilink, input logic iret,
                              input logic bht, input logic pcm, input logic flush);
        logic restore;
        logic push;
        logic pop;
        int   old_bp;
`ifdef AQ_IFU_RAS_OCC_CHK_EN
        int   old_bc;
        old_bc = m_bc;
`endif
        restore = flush | bht | (pcm & ~ilink);
        push    = plink;
        pop     = pret & ~cst;
`ifdef AQ_IFU_RAS_OCC_CHK_EN
        pop = pop & (m_sc != 0);
`endif
        old_bp = m_bp;
        if (!flush) begin
            if (ilink && !iret) begin
                m_bp = (m_bp + 1) % DEPTH;
`ifdef AQ_IFU_RAS_OCC_CHK_EN
                if (m_bc < DEPTH) m_bc++;
`endif
            end else if (iret && !ilink) begin
                m_bp = (m_bp + DEPTH - 1) % DEPTH;
`ifdef AQ_IFU_RAS_OCC_CHK_EN
                if (m_bc > 0) m_bc--;
`endif
            end
        end
        if (restore) begin
            m_sp = old_bp;
`ifdef AQ_IFU_RAS_OCC_CHK_EN
            m_sc = old_bc;
`endif
        end else if (push && pop) begin
            m_stk[m_sp] = lpc;
        end else if (push) begin
            m_sp = (m_sp + 1) % DEPTH;
            m_stk[m_sp] = lpc;
`ifdef AQ_IFU_RAS_OCC_CHK_EN
            if (m_sc < DEPTH) m_sc++;
`endif
        end else if (pop) begin
            m_sp = (m_sp + DEPTH - 1) % DEPTH;
`ifdef AQ_IFU_RAS_OCC_CHK_EN
            m_sc--;
`endif
        end
    endtask

    // One transaction: drive, clock, update model, compare. Called at posedge+1.
    task automatic drive(input string tag, input logic plink, input logic [PC_W-1:0] lpc,
                         input logic pret, input logic cst,
                         input logic ilink, input logic iret,
                         input logic bht, input logic pcm, input logic flush);
        pred_ras_link_vld  = plink;
        pred_ras_link_pc   = lpc;
        pred_ras_ret_vld   = pret;
        ras_cur_st         = cst;
        iu_ifu_link_vld    = ilink;
        iu_ifu_ret_vld     = iret;
        iu_ifu_bht_mispred = bht;
        iu_ifu_pc_mispred  = pcm;
        rtu_ifu_flush_fe   = flush;
        @(posedge clk);
        model_step(plink, lpc, pret, cst, ilink, iret, bht, pcm, flush);
        #1;
        $display("txn %s: link=%b pc=0x%0h ret=%b st=%b ilink=%b iret=%b bht=%b pcm=%b flush=%b -> tar=0x%0h vld=%b",
                 tag, plink, lpc, pret, cst, ilink, iret, bht, pcm, flush,
                 ras_pred_tar_pc, ras_pred_vld);
        chk_pc({tag, "_tar"}, ras_pred_tar_pc, m_stk[m_sp]);
        chk_bit({tag, "_vld"}, ras_pred_vld, model_vld());
    endtask

    task automatic idle_inputs();
        pred_ras_link_vld  = 1'b0;
        pred_ras_link_pc   = '0;
        pred_ras_ret_vld   = 1'b0;
        ras_cur_st         = 1'b0;
        iu_ifu_link_vld    = 1'b0;
        iu_ifu_ret_vld     = 1'b0;
        iu_ifu_bht_mispred = 1'b0;
        iu_ifu_pc_mispred  = 1'b0;
        rtu_ifu_flush_fe   = 1'b0;
    endtask

    // Asserts reset mid-cycle with whatever inputs are currently driven,
    // holds it across a clock edge, then releases. Returns at posedge+1.
    task automatic apply_reset(input string tag);
        #2;
        cpurst_b = 1'b0;
        model_reset();
        #1;
        chk_pc({tag, "_rst_tar"}, ras_pred_tar_pc, '0);
        chk_bit({tag, "_rst_vld"}, ras_pred_vld, model_vld());
        @(posedge clk);
        #1;
        idle_inputs();
        cpurst_b = 1'b1;
        #1;
        $display("txn %s: reset -> tar=0x%0h vld=%b", tag, ras_pred_tar_pc, ras_pred_vld);
        chk_pc({tag, "_post_tar"}, ras_pred_tar_pc, '0);
        chk_bit({tag, "_post_vld"}, ras_pred_vld, model_vld());
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks           = 0;
        n_pass             = 0;
        cpurst_b           = 1'b0;
        cp0_ifu_icg_en     = 1'b0;
        cp0_yy_clk_en      = 1'b1;
        pad_yy_icg_scan_en = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        apply_reset("init");

        // Three pushes then three pops.
        drive("p100", 1, 24'h100, 0, 0, 0, 0, 0, 0, 0);
        drive("p200", 1, 24'h200, 0, 0, 0, 0, 0, 0, 0);
        drive("p300", 1, 24'h300, 0, 0, 0, 0, 0, 0, 0);
        chk_pc("lifo_top", ras_pred_tar_pc, 24'h300);
        drive("pop1", 0, '0, 1, 0, 0, 0, 0, 0, 0);
        chk_pc("lifo_pop1", ras_pred_tar_pc, 24'h200);
        drive("pop2", 0, '0, 1, 0, 0, 0, 0, 0, 0);
        chk_pc("lifo_pop2", ras_pred_tar_pc, 24'h100);
        drive("pop3", 0, '0, 1, 0, 0, 0, 0, 0, 0);
`ifdef AQ_IFU_RAS_OCC_CHK_EN
        chk_bit("lifo_empty_vld", ras_pred_vld, 1'b0);
`else
        chk_bit("lifo_vld_tied", ras_pred_vld, 1'b1);
`endif

        // Overflow: nine pushes wrap over the oldest entry.
        apply_reset("ovf");
        for (int i = 1; i <= 9; i++) drive("ovf_push", 1, PC_W'(i), 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            chk_pc("ovf_seq", ras_pred_tar_pc, PC_W'(9 - k));
            drive("ovf_pop", 0, '0, 1, 0, 0, 0, 0, 0, 0);
        end

        // pc_mispred without link restores sptr to bptr=0 and drops a push.
        apply_reset("mis");
        drive("mis_p1", 1, 24'hA1, 0, 0, 0, 0, 0, 0, 0);
        drive("mis_p2", 1, 24'hA2, 0, 0, 0, 0, 0, 0, 0);
        drive("mis_rst", 1, 24'hBB, 0, 0, 0, 0, 0, 1, 0);
        chk_pc("mis_restore", ras_pred_tar_pc, 24'h0);
        drive("mis_p3", 1, 24'hCC, 0, 0, 0, 0, 0, 0, 0);
        chk_pc("mis_after", ras_pred_tar_pc, 24'hCC);

        // Same-cycle push and pop replaces the top.
        apply_reset("rep");
        drive("rep_p", 1, 24'h333, 0, 0, 0, 0, 0, 0, 0);
        drive("rep_pp", 1, 24'h444, 1, 0, 0, 0, 0, 0, 0);
        chk_pc("rep_top", ras_pred_tar_pc, 24'h444);
        drive("rep_pop", 0, '0, 1, 0, 0, 0, 0, 0, 0);
        chk_pc("rep_depth", ras_pred_tar_pc, 24'h0);

        // Suppressed pop.
        apply_reset("sup");
        drive("sup_p", 1, 24'h555, 0, 0, 0, 0, 0, 0, 0);
        drive("sup_ret", 0, '0, 1, 1, 0, 0, 0, 0, 0);
        chk_pc("sup_keep", ras_pred_tar_pc, 24'h555);

        // iu link together with flush: bptr frozen, sptr takes old bptr.
        apply_reset("fl");
        drive("fl_a", 1, 24'h10, 0, 0, 1, 0, 0, 0, 0);
        drive("fl_b", 1, 24'h20, 0, 0, 0, 0, 0, 0, 0);
        drive("fl_c", 0, '0, 0, 0, 1, 0, 0, 0, 1);
        chk_pc("fl_sptr", ras_pred_tar_pc, 24'h10);
        drive("fl_d", 0, '0, 0, 0, 0, 0, 0, 0, 1);
        chk_pc("fl_bptr", ras_pred_tar_pc, 24'h10);

        // Random traffic with one reset asserted in the middle of a push.
        apply_reset("rnd");
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                pred_ras_link_vld = 1'b1;
                pred_ras_link_pc  = 24'hDEAD;
                apply_reset("rnd_mid");
            end
            drive("rnd",
                  1'($urandom_range(0, 1)), PC_W'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 11) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
